// File: rtl/simon_pkt_rx_queue.sv
// Packet receive queue: 4-phase new/load/done host handshake in, DEPTH-entry FIFO of decoded key/data packets out.
// Capture-to-in_loadPKT 1 cycle, head valid the cycle after capture; while full the host is held off in IDLE.
module simon_pkt_rx_queue #(
  parameter int         PAY_BYTES = 8,
  parameter int         DEPTH     = 4,
  parameter logic [7:0] ID_KEY    = 8'hC3,
  parameter logic [7:0] ID_DATA   = 8'h5A
) (
  input  logic                         clk,
  input  logic                         nR,
  input  logic [(PAY_BYTES+2)*8-1:0]   in,
  input  logic                         in_newPKT,
  output logic                         in_loadPKT,
  output logic                         in_donePKT,
  output logic                         core_valid,
  input  logic                         core_ready,
  output logic                         core_isKEY,
  output logic [7:0]                   core_seq,
  output logic [PAY_BYTES*8-1:0]       core_data,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         err_seq,
  output logic                         err_hdr,
  output logic [7:0]                   drop_cnt,
  input  logic                         err_clr
);
  localparam int PayW = PAY_BYTES * 8;
  localparam int PktW = PayW + 16;
  localparam int AW   = $clog2(DEPTH);
  localparam logic [AW:0] Full = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;

  logic [7:0]      hdr, seq, expSeq;
  logic [PayW-1:0] payload;
  logic [AW-1:0]   wrPtr, rdPtr;
  logic            memKey  [DEPTH];
  logic [7:0]      memSeq  [DEPTH];
  logic [PayW-1:0] memData [DEPTH];
  logic            pop, capture, isKey, isData, push, badHdr, seqErr;

  assign hdr     = in[PktW-1 -: 8];
  assign seq     = in[PktW-9 -: 8];
  assign payload = in[PayW-1:0];

  assign core_valid = (level != '0);
  assign pop        = core_valid && core_ready;
  // A full queue still accepts a packet when the head leaves on the same edge.
  assign capture    = (state == IDLE) && in_newPKT && ((level != Full) || pop);
  assign isKey      = (hdr == ID_KEY);
  assign isData     = (hdr == ID_DATA);
  assign push       = capture && (isKey || isData);
  assign badHdr     = capture && !isKey && !isData;
  assign seqErr     = capture && isData && (seq != expSeq);

  assign core_isKEY = memKey[rdPtr];
  assign core_seq   = memSeq[rdPtr];
  assign core_data  = memData[rdPtr];

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state      <= IDLE;
      in_loadPKT <= 1'b0;
      in_donePKT <= 1'b0;
    end else begin
      case (state)
        IDLE: if (capture) begin
          state      <= LOAD;
          in_loadPKT <= 1'b1;
        end
        LOAD: if (!in_newPKT) begin
          state      <= DONE;
          in_loadPKT <= 1'b0;
          in_donePKT <= 1'b1;
        end
        DONE: begin
          state      <= IDLE;
          in_donePKT <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          in_loadPKT <= 1'b0;
          in_donePKT <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        memKey[i]  <= 1'b0;
        memSeq[i]  <= '0;
        memData[i] <= '0;
      end
    end else begin
      if (push) begin
        memKey[wrPtr]  <= isKey;
        memSeq[wrPtr]  <= seq;
        memData[wrPtr] <= payload;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      expSeq   <= '0;
      err_seq  <= 1'b0;
      err_hdr  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (capture && isKey)  expSeq <= '0;
      if (capture && isData) expSeq <= seq + 8'd1;
      if (err_clr) begin
        err_seq  <= 1'b0;
        err_hdr  <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (seqErr) err_seq <= 1'b1;
        if (badHdr) err_hdr <= 1'b1;
        if (badHdr && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
endmodule
